// File: rtl/rca_pipe_pkg.sv
`default_nettype none
// ============================================================================
// rca_pipe_pkg: shared types and elaboration helpers for rca_pipe_param
// Revision: 1.0
// ============================================================================
package rca_pipe_pkg;

    localparam int RESULT_MAX_W = 64;

    // Result bundle for consumers; sum is sized for the widest instance and
    // narrower adders occupy the low bits.
    typedef struct packed {
        logic                    cout;
        logic                    ovf;
        logic [RESULT_MAX_W-1:0] sum;
    } rca_result_t;

    function automatic int nstages(input int width, input int stage_bits);
        return width / stage_bits;
    endfunction

    function automatic bit params_ok(input int width, input int stage_bits);
        return (stage_bits >= 1) && (stage_bits <= width) && ((width % stage_bits) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_chunk.sv
`default_nettype none
// ============================================================================
// rca_chunk: combinational BITS-wide ripple adder slice with carry into MSB
// Revision: 1.0
// ============================================================================
module rca_chunk #(
    parameter int BITS = 2
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            ci,
    output logic [BITS-1:0] s,
    output logic            co,
    output logic            c_msb
);

    logic c;

    always_comb begin
        c     = ci;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < BITS; i++) begin
            if (i == BITS - 1) begin
                c_msb = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule
`default_nettype wire

// File: rtl/rca_pipe_param.sv
`default_nettype none
// ============================================================================
// rca_pipe_param: bit-sliced pipelined ripple-carry adder/subtractor, valid/ready
// Revision: 1.0
// ============================================================================
module rca_pipe_param
    import rca_pipe_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGES = nstages(WIDTH, STAGE_BITS);

    if (!params_ok(WIDTH, STAGE_BITS)) begin : g_param_check
        $error("rca_pipe_param: WIDTH must be a positive multiple of STAGE_BITS");
    end

    // Index 0 is the input register; index k+1 is the register after chunk
    // stage k. acc_q shifts right by one chunk per stage: the low bits hold the
    // A operand still to be consumed, the high bits the result chunks so far.
    logic [WIDTH-1:0]      acc_q    [NSTAGES+1];
    logic [WIDTH-1:0]      bop_q    [NSTAGES];
    logic                  cy_q     [NSTAGES+1];
    logic                  vld_q    [NSTAGES+1];
    logic                  ovf_q;

    logic [STAGE_BITS-1:0] chunk_s  [NSTAGES];
    logic                  chunk_co [NSTAGES];
    logic                  chunk_cm [NSTAGES];

    logic [WIDTH-1:0]      sum_q;
    logic                  cout_q;
    logic                  ovf_out_q;
    logic                  out_valid_q;
    logic                  stall;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q[0] <= 1'b0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
        end
        if (!stall) begin
            acc_q[0] <= a;
            bop_q[0] <= sub ? ~b : b;
            cy_q[0]  <= sub ? ~cin : cin;
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        rca_chunk #(
            .BITS (STAGE_BITS)
        ) u_chunk (
            .a     (acc_q[k][STAGE_BITS-1:0]),
            .b     (bop_q[k][STAGE_BITS-1:0]),
            .ci    (cy_q[k]),
            .s     (chunk_s[k]),
            .co    (chunk_co[k]),
            .c_msb (chunk_cm[k])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[k+1] <= 1'b0;
            end else if (!stall) begin
                vld_q[k+1] <= vld_q[k];
            end
            if (!stall) begin
                acc_q[k+1] <= (acc_q[k] >> STAGE_BITS)
                            | (WIDTH'(chunk_s[k]) << (WIDTH - STAGE_BITS));
                cy_q[k+1]  <= chunk_co[k];
            end
        end

        // Consumed B chunks are shifted out; the zero fill is constant and
        // leaves only the unconsumed upper chunks as real storage.
        if (k < NSTAGES - 1) begin : g_fwd_b
            always_ff @(posedge clk) begin
                if (!stall) begin
                    bop_q[k+1] <= bop_q[k] >> STAGE_BITS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            ovf_q <= chunk_cm[NSTAGES-1] ^ chunk_co[NSTAGES-1];
        end
    end

    // Result fields only load on a valid entry so they hold through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= vld_q[NSTAGES];
            if (vld_q[NSTAGES]) begin
                sum_q     <= acc_q[NSTAGES];
                cout_q    <= cy_q[NSTAGES];
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_out_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_pipe_param.sv
`default_nettype none
// ============================================================================
// tb_rca_pipe_param: directed self-checking bench for rca_pipe_param
// Revision: 1.0
// ============================================================================
module tb_rca_pipe_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    logic        sw_valid, sw_ready, sw_cin, sw_sub;
    logic [15:0] sw_a, sw_b;
    logic        q4_ready, q4_valid, q4_cout, q4_ovf;
    logic [15:0] q4_sum;
    logic        q16_ready, q16_valid, q16_cout, q16_ovf;
    logic [15:0] q16_sum;
    logic        q1_ready, q1_valid, q1_cout, q1_ovf;
    logic [7:0]  q1_sum;

    int n_checks = 0;
    int n_fail   = 0;

    rca_pipe_param #(.WIDTH(8), .STAGE_BITS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    rca_pipe_param #(.WIDTH(16), .STAGE_BITS(4)) dut16_4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(q4_ready),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
        .out_valid(q4_valid), .out_ready(sw_ready),
        .sum(q4_sum), .cout(q4_cout), .ovf(q4_ovf)
    );

    rca_pipe_param #(.WIDTH(16), .STAGE_BITS(16)) dut16_16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(q16_ready),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
        .out_valid(q16_valid), .out_ready(sw_ready),
        .sum(q16_sum), .cout(q16_cout), .ovf(q16_ovf)
    );

    rca_pipe_param #(.WIDTH(8), .STAGE_BITS(1)) dut8_1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(q1_ready),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(q1_valid), .out_ready(sw_ready),
        .sum(q1_sum), .cout(q1_cout), .ovf(q1_ovf)
    );

    // Reference: {cout, ovf, sum[15:0]} for a w-bit operation.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic sb);
        logic [31:0] mask, xx, bb, full, s;
        logic        co, ov;
        mask = (32'd1 << w) - 32'd1;
        xx   = {16'h0, x} & mask;
        bb   = (sb ? ~{16'h0, y} : {16'h0, y}) & mask;
        full = xx + bb + {31'd0, (sb ? ~ci : ci)};
        s    = full & mask;
        co   = full[w];
        ov   = (xx[w-1] == bb[w-1]) && (s[w-1] != xx[w-1]);
        return {co, ov, s[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b1; sw_a = 16'h1234; sw_b = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        rst = 1'b0; in_valid = 1'b0; sw_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b0 || q4_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_discard cycle %0d: got out_valid %b/%b expected 0/0", i, out_valid, q4_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single(input string name, input logic [7:0] xa, input logic [7:0] xb,
                               input logic xc, input logic xs,
                               input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL %s latency: got %0d expected 5", name, lat); end
        n_checks++; if (sum !== e_sum) begin n_fail++; $display("FAIL %s sum: got %h expected %h", name, sum, e_sum); end
        n_checks++; if (cout !== e_cout) begin n_fail++; $display("FAIL %s cout: got %b expected %b", name, cout, e_cout); end
        n_checks++; if (ovf !== e_ovf) begin n_fail++; $display("FAIL %s ovf: got %b expected %b", name, ovf, e_ovf); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s drain: got out_valid %b expected 0", name, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [20];
        logic [7:0]  tb_ [20];
        logic        tc [20];
        logic        ts [20];
        logic [17:0] r;
        logic        expv;
        int          i;
        ta[0] = 8'hFF; tb_[0] = 8'h01; tc[0] = 1'b1; ts[0] = 1'b0;
        for (int k = 1; k < 20; k++) begin
            ta[k] = 8'($urandom); tb_[k] = 8'($urandom);
            tc[k] = 1'($urandom); ts[k] = 1'($urandom);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 28; j++) begin
            if (j < 20) begin
                a = ta[j]; b = tb_[j]; cin = tc[j]; sub = ts[j]; in_valid = 1'b1;
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready op %0d: got %b expected 1", j, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            i = j - 5;
            expv = (i >= 0 && i < 20);
            n_checks++;
            if (out_valid !== expv) begin n_fail++; $display("FAIL b2b out_valid cycle %0d: got %b expected %b", j, out_valid, expv); end
            if (expv) begin
                r = ref_op(8, {8'h00, ta[i]}, {8'h00, tb_[i]}, tc[i], ts[i]);
                n_checks++;
                if ({cout, ovf, sum} !== {r[17], r[16], r[7:0]}) begin
                    n_fail++; $display("FAIL b2b result op %0d: got c%b v%b %h expected c%b v%b %h", i, cout, ovf, sum, r[17], r[16], r[7:0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  va [10];
        logic [7:0]  vb [10];
        logic        vc [10];
        logic        vs [10];
        logic [17:0] r;
        int          tx, rx, cyc, drop;
        bit          dropped;
        va = '{8'h01, 8'h80, 8'hFE, 8'h10, 8'h7F, 8'h55, 8'h00, 8'hC3, 8'h99, 8'h33};
        vb = '{8'h02, 8'h80, 8'h03, 8'h11, 8'h7F, 8'hAA, 8'h01, 8'h3C, 8'h66, 8'h44};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tx = 0; rx = 0; cyc = 0; drop = 0; dropped = 1'b0;
        while (rx < 10 && cyc < 80) begin
            if (!dropped && rx == 3) begin drop = 3; dropped = 1'b1; end
            out_ready = (drop == 0);
            in_valid  = (tx < 10);
            if (tx < 10) begin a = va[tx]; b = vb[tx]; cin = vc[tx]; sub = vs[tx]; end
            #1;
            if (drop > 0) begin
                r = ref_op(8, {8'h00, va[rx]}, {8'h00, vb[rx]}, vc[rx], vs[rx]);
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready during stall: got %b expected 0", in_ready); end
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp out_valid during stall: got %b expected 1", out_valid); end
                n_checks++; if (sum !== r[7:0]) begin n_fail++; $display("FAIL bp held sum: got %h expected %h", sum, r[7:0]); end
                drop--;
            end
            if (in_valid && in_ready) tx++;
            if (out_valid && out_ready) begin
                r = ref_op(8, {8'h00, va[rx]}, {8'h00, vb[rx]}, vc[rx], vs[rx]);
                n_checks++;
                if ({cout, ovf, sum} !== {r[17], r[16], r[7:0]}) begin
                    n_fail++; $display("FAIL bp result %0d: got c%b v%b %h expected c%b v%b %h", rx, cout, ovf, sum, r[17], r[16], r[7:0]);
                end
                rx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (rx != 10) begin n_fail++; $display("FAIL bp timeout: got %0d results expected 10", rx); end
        n_checks++; if (tx != 10) begin n_fail++; $display("FAIL bp accepted: got %0d expected 10", tx); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp duplicate cycle %0d: got out_valid %b expected 0", k, out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a = 8'h20 + 8'(j); b = 8'h11; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL midrst sum: got %h expected 00", sum); end
        n_checks++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL midrst flags: got %b%b expected 00", cout, ovf); end
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst flush cycle %0d: got out_valid %b expected 0", k, out_valid); end
            @(posedge clk); #1;
        end
        test_single("midrst_recover", 8'h05, 8'h03, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0);
    endtask

    task automatic test_param_sweep();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vc [6];
        logic        vs [6];
        logic        ov, oc, oo, ir, expv;
        logic [15:0] os;
        logic [17:0] r;
        int          w, lat, i;
        va = '{16'h7FFF, 16'hFFFF, 16'h1234, 16'h8000, 16'h00FF, 16'hA5A5};
        vb = '{16'h0001, 16'h0001, 16'h4321, 16'h0001, 16'h0F01, 16'h5A5A};
        vc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        sw_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            if (j < 6) begin
                sw_a = va[j]; sw_b = vb[j]; sw_cin = vc[j]; sw_sub = vs[j]; sw_valid = 1'b1;
            end else begin
                sw_valid = 1'b0;
            end
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                case (d)
                    0: begin w = 16; lat = 5; ov = q4_valid;  os = q4_sum;  oc = q4_cout;  oo = q4_ovf;  ir = q4_ready;  end
                    1: begin w = 16; lat = 2; ov = q16_valid; os = q16_sum; oc = q16_cout; oo = q16_ovf; ir = q16_ready; end
                    default: begin w = 8; lat = 9; ov = q1_valid; os = {8'h00, q1_sum}; oc = q1_cout; oo = q1_ovf; ir = q1_ready; end
                endcase
                i = j - lat;
                expv = (i >= 0 && i < 6);
                n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL sweep w%0d lat%0d in_ready: got %b expected 1", w, lat, ir); end
                n_checks++; if (ov !== expv) begin n_fail++; $display("FAIL sweep w%0d lat%0d out_valid cycle %0d: got %b expected %b", w, lat, j, ov, expv); end
                if (expv) begin
                    r = ref_op(w, va[i], vb[i], vc[i], vs[i]);
                    n_checks++;
                    if ({oc, oo, os} !== r) begin
                        n_fail++; $display("FAIL sweep w%0d lat%0d op %0d: got c%b v%b %h expected c%b v%b %h", w, lat, i, oc, oo, os, r[17], r[16], r[15:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        test_reset();
        test_single("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        test_single("sub_borrow", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        test_single("sub_cin", 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        test_single("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        test_single("add_wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rca_pipe_param.md
# rca_pipe_param

Parametrised, bit-sliced pipelined ripple-carry adder/subtractor with valid/ready flow control. It splits a WIDTH-bit operation into NSTAGES = WIDTH/STAGE_BITS chunk stages and accepts one operation per cycle. Operand skew and result deskew are handled internally. It serves as the generic arithmetic datapath block in place of fixed-width, fixed-depth pipelined adders.

## Interface
Parameters:
- WIDTH, 8: operand/result width; must be a multiple of STAGE_BITS.
- STAGE_BITS, 2: bits resolved per pipeline stage; 1 ≤ STAGE_BITS ≤ WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry-out of MSB chunk (sub: 1 = no borrow).
- ovf  out  1  signed overflow.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Effective operands: B' = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Input register captures a, B', c0, sub and a valid bit.
- Stage k (k = 0..NSTAGES−1) adds chunk k of A and B' plus the carry from stage k−1, or c0 for k = 0. It forwards:
  - its result chunk plus all lower chunks already computed;
  - the unconsumed upper operand chunks;
  - the carry;
  - its valid bit.
- Final stage also computes ovf = carry into MSB XOR carry out of MSB.
- Output register holds {cout, ovf, sum} and out_valid.
- Global stall: stall = out_valid && !out_ready. While stalled:
  - every pipeline register, including valid bits, holds;
  - in_ready = 0.
- Otherwise in_ready = 1 and all stages advance. Bubbles (valid = 0) advance like data.
- Data fields of invalid entries are don't-care internally. sum/cout/ovf change only when a valid result is loaded.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset: all valid bits → 0; sum, cout, ovf → 0; out_valid = 0. in_ready = 1 from the cycle after reset deasserts.
- Inputs presented while rst = 1 are discarded.
- Latency: operation accepted at edge t appears with out_valid = 1 after edge t + NSTAGES + 1 (input reg, NSTAGES chunk regs, output reg = NSTAGES+2 registers; count from the capturing edge).
- For WIDTH = 8, STAGE_BITS = 2, this is 5 cycles.
- Throughput: 1 result per cycle when out_ready stays high.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and loses nothing.
- Reset mid-operation flushes every in-flight entry. Nothing is emitted afterward.
- STAGE_BITS = WIDTH is legal: one chunk stage, latency 2.

## Structure
- Package rca_pipe_pkg:
  - function nstages(WIDTH, STAGE_BITS);
  - elaboration check that WIDTH % STAGE_BITS == 0;
  - result struct type {cout, ovf, sum} usable by consumers.
- Sub-module rca_chunk:
  - combinational STAGE_BITS-bit ripple adder;
  - inputs a, b, ci; outputs s, co, and carry-into-MSB;
  - instantiated NSTAGES times via generate.
- Top holds the input register, per-stage registers with shrinking operand fields, the output register and the stall logic.

## Test plan
- Reset then single add, WIDTH = 8, STAGE_BITS = 2: a = 0x7F, b = 0x01, cin = 0, sub = 0. Expect sum = 0x80, cout = 0, ovf = 1, out_valid exactly 5 cycles after acceptance.
- Subtract with borrow: a = 0x10, b = 0x20, sub = 1, cin = 0. Expect sum = 0xF0, cout = 0. Then a = 0x20, b = 0x10, cin = 1: sum = 0x0F, cout = 1, ovf = 0.
- Back-to-back stream of 20 random ops with out_ready = 1: one result per cycle, in order, matching reference model; include a = 0xFF, b = 0x01, cin = 1 → sum = 0x01, cout = 1.
- Backpressure: stream 10 ops, drop out_ready for 3 cycles mid-stream.
  - in_ready = 0 during the drop; outputs hold stable.
  - No loss or duplication, order preserved.
- Reset mid-stream: assert rst with 4 ops in flight. No out_valid afterward until new input; outputs read 0.
- Parameter sweep: (WIDTH, STAGE_BITS) = (16, 4), (16, 16), (8, 1). Random ops; latency NSTAGES + 1 and results correct for each.
